// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard_stall_unit signal bundle: ID/EX hazard inputs in, stall/busy controls out.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_IFID_RegisterRs;
    logic [4:0]       i_IFID_RegisterRt;
    logic             i_IFID_UsesRt;
    logic             i_IFID_MulDiv;
    logic             i_IFID_ReadHiLo;
    logic             i_IDEX_MemRead;
    logic [4:0]       i_IDEX_RegisterRt;
    logic             i_Branch_Flush;
    logic             o_PCWrite;
    logic             o_IFIDWrite;
    logic             o_IDEX_Bubble;
    logic             o_MulDiv_Busy;
    logic             o_MulDiv_Done;
    logic [CNT_W-1:0] o_stall_cycles;

    modport master (
        output i_IFID_RegisterRs, i_IFID_RegisterRt, i_IFID_UsesRt, i_IFID_MulDiv,
               i_IFID_ReadHiLo, i_IDEX_MemRead, i_IDEX_RegisterRt, i_Branch_Flush,
        input  o_PCWrite, o_IFIDWrite, o_IDEX_Bubble, o_MulDiv_Busy, o_MulDiv_Done,
               o_stall_cycles
    );

    modport slave (
        input  i_IFID_RegisterRs, i_IFID_RegisterRt, i_IFID_UsesRt, i_IFID_MulDiv,
               i_IFID_ReadHiLo, i_IDEX_MemRead, i_IDEX_RegisterRt, i_Branch_Flush,
        output o_PCWrite, o_IFIDWrite, o_IDEX_Bubble, o_MulDiv_Busy, o_MulDiv_Done,
               o_stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use and MULT/DIV busy stall detection with the multiply/divide countdown timer.
// Optional saturating stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_stall_unit #(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_W          = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    hazard_stall_unit_if.slave     hs
);
    localparam int CW = $clog2(MULDIV_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MULDIV_LATENCY);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lu, md, stall, issue;

    always_comb begin
        lu = hs.i_IDEX_MemRead && (hs.i_IDEX_RegisterRt != 5'd0) &&
             ((hs.i_IDEX_RegisterRt == hs.i_IFID_RegisterRs) ||
              (hs.i_IFID_UsesRt && (hs.i_IDEX_RegisterRt == hs.i_IFID_RegisterRt)));
        md    = (cnt_q != '0) && (hs.i_IFID_ReadHiLo || hs.i_IFID_MulDiv);
        // A squashed ID instruction is discarded anyway, so it neither stalls nor issues.
        stall = (lu || md) && !hs.i_Branch_Flush;
        issue = hs.i_IFID_MulDiv && !stall && !hs.i_Branch_Flush;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (issue)
            cnt_d = LAT;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign hs.o_PCWrite     = !stall;
    assign hs.o_IFIDWrite   = !stall;
    assign hs.o_IDEX_Bubble = stall;
    assign hs.o_MulDiv_Busy = (cnt_q != '0);
    assign hs.o_MulDiv_Done = (cnt_q == CW'(1));

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign hs.o_stall_cycles = stall_cnt_q;
`else
    assign hs.o_stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit with MULDIV_LATENCY=4 and an 8-bit stall counter.
module tb_hazard_stall_unit;
    localparam int LAT   = 4;
    localparam int CNT_W = 8;

    typedef struct {
        int pcw;
        int ifw;
        int bub;
        int busy;
        int done;
        int sc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   m_cnt;
    int   m_sc;
    exp_t sb[$];

    hazard_stall_unit_if #(.CNT_W(CNT_W)) hs ();

    hazard_stall_unit #(.MULDIV_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .hs      (hs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want test done");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Drive one ID/EX pattern, predict outputs, compare, then retire the cycle in the model.
    task automatic step(input string tag, input int rs, input int rt, input int uses_rt,
                        input int muldiv, input int rdhilo, input int memrd, input int exrt,
                        input int flush);
        exp_t e;
        exp_t g;
        int   lu;
        int   md;
        int   st;
        int   iss;
        @(negedge clk);
        hs.i_IFID_RegisterRs = 5'(rs);
        hs.i_IFID_RegisterRt = 5'(rt);
        hs.i_IFID_UsesRt     = 1'(uses_rt);
        hs.i_IFID_MulDiv     = 1'(muldiv);
        hs.i_IFID_ReadHiLo   = 1'(rdhilo);
        hs.i_IDEX_MemRead    = 1'(memrd);
        hs.i_IDEX_RegisterRt = 5'(exrt);
        hs.i_Branch_Flush    = 1'(flush);
        lu  = (memrd != 0 && exrt != 0 && (exrt == rs || (uses_rt != 0 && exrt == rt))) ? 1 : 0;
        md  = (m_cnt != 0 && (rdhilo != 0 || muldiv != 0)) ? 1 : 0;
        st  = ((lu != 0 || md != 0) && flush == 0) ? 1 : 0;
        iss = (muldiv != 0 && st == 0 && flush == 0) ? 1 : 0;
        e.pcw  = 1 - st;
        e.ifw  = 1 - st;
        e.bub  = st;
        e.busy = (m_cnt != 0) ? 1 : 0;
        e.done = (m_cnt == 1) ? 1 : 0;
        e.sc   = m_sc;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chk({tag, ".pcw"},  int'(hs.o_PCWrite),     g.pcw);
        chk({tag, ".ifw"},  int'(hs.o_IFIDWrite),   g.ifw);
        chk({tag, ".bub"},  int'(hs.o_IDEX_Bubble), g.bub);
        chk({tag, ".busy"}, int'(hs.o_MulDiv_Busy), g.busy);
        chk({tag, ".done"}, int'(hs.o_MulDiv_Done), g.done);
        chk({tag, ".sc"},   int'(hs.o_stall_cycles), g.sc);
        @(posedge clk);
        if (iss != 0)
            m_cnt = LAT;
        else if (m_cnt != 0)
            m_cnt = m_cnt - 1;
`ifdef HAZARD_STALL_CNT_EN
        if (st != 0 && m_sc != 255)
            m_sc = m_sc + 1;
`endif
    endtask

    task automatic nop(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_cnt = 0;
        m_sc  = 0;
        rst_n = 1'b0;
        hs.i_IFID_RegisterRs = '0;
        hs.i_IFID_RegisterRt = '0;
        hs.i_IFID_UsesRt     = 1'b0;
        hs.i_IFID_MulDiv     = 1'b0;
        hs.i_IFID_ReadHiLo   = 1'b0;
        hs.i_IDEX_MemRead    = 1'b0;
        hs.i_IDEX_RegisterRt = '0;
        hs.i_Branch_Flush    = 1'b0;
        #12;
        chk("rst.busy", int'(hs.o_MulDiv_Busy), 0);
        chk("rst.done", int'(hs.o_MulDiv_Done), 0);
        chk("rst.sc",   int'(hs.o_stall_cycles), 0);
        chk("rst.pcw",  int'(hs.o_PCWrite), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // load-use on rs, then released
        step("lu_rs",   9, 3, 1, 0, 0, 1, 9, 0);
        step("lu_rel",  4, 5, 1, 0, 0, 0, 9, 0);
        // load-use on rt
        step("lu_rt",   4, 9, 1, 0, 0, 1, 9, 0);
        // $0 destination and rt not used: no stall
        step("lu_zero", 0, 0, 1, 0, 0, 1, 0, 0);
        step("lu_nort", 4, 9, 0, 0, 0, 1, 9, 0);

        // MULT issues, MFLO waits through the countdown
        step("mult",    1, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < LAT; i++)
            step("mflo_st", 0, 0, 0, 0, 1, 0, 0, 0);
        step("mflo_go", 0, 0, 0, 0, 1, 0, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
        chk("sc_six", int'(hs.o_stall_cycles), 6);
`else
        chk("sc_six", int'(hs.o_stall_cycles), 0);
`endif
        nop("idle");

        // flushed DIV behind a busy MULT: no stall, no reload
        step("mult2",   1, 2, 1, 1, 0, 0, 0, 0);
        step("div_fl",  1, 2, 1, 1, 0, 0, 0, 1);
        step("div_st",  1, 2, 1, 1, 0, 0, 0, 0);
        step("div_st2", 1, 2, 1, 1, 0, 0, 0, 0);
        step("div_st3", 1, 2, 1, 1, 0, 0, 0, 0);
        step("div_iss", 1, 2, 1, 1, 0, 0, 0, 0);
        // flush also masks load-use
        step("lu_fl",   9, 3, 1, 0, 0, 1, 9, 1);
        // simultaneous load-use and HI/LO hazard: one stall
        step("both",    9, 3, 1, 0, 1, 1, 9, 0);
        for (int i = 0; i < LAT; i++)
            nop("drain");

        // reset mid-countdown at cnt=3
        step("mult3",   1, 2, 1, 1, 0, 0, 0, 0);
        nop("cnt4");
        @(negedge clk);
        hs.i_IFID_ReadHiLo = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", int'(hs.o_MulDiv_Busy), 0);
        chk("arst.done", int'(hs.o_MulDiv_Done), 0);
        chk("arst.pcw",  int'(hs.o_PCWrite), 1);
        chk("arst.bub",  int'(hs.o_IDEX_Bubble), 0);
        chk("arst.sc",   int'(hs.o_stall_cycles), 0);
        m_cnt = 0;
        m_sc  = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 0, 0, 0, 1, 0, 0, 0);

        // L=4 single-stall boundary: done exactly on last busy cycle
        step("mult4", 1, 2, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < LAT + 1; i++)
            nop("cnt_dn");

        // long held load-use to reach counter saturation
        for (int i = 0; i < 260; i++)
            step("sat", 7, 0, 0, 0, 0, 1, 7, 0);
`ifdef HAZARD_STALL_CNT_EN
        chk("sc_sat", int'(hs.o_stall_cycles), 255);
`else
        chk("sc_sat", int'(hs.o_stall_cycles), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
